// File: rtl/lvds_frame_rx.sv
// lvds_frame_rx: flag-delimited frame receiver with length/checksum checking and buffered payload replay
module lvds_frame_rx #(
  parameter int         DEPTH = 64,
  parameter logic [7:0] FLAG  = 8'h7E
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_st_flag_i,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output logic       m_sof_o,
  output logic       m_eof_o,
  output logic       frame_ok_o,
  output logic       frame_err_o,
  output logic [1:0] err_code_o,
  output logic       drop_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CHK, END, DRAIN} state_t;
  state_t state_q, state_d;
  logic [7:0] len_q, len_d, chk_q, chk_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] err_code_q, err_code_d;
  logic frame_ok_q, frame_ok_d, frame_err_q, frame_err_d, drop_q, drop_d;
  logic [7:0] buf_q [DEPTH];
  logic wr_en, is_flag, bad_flag, last_wr, last_rd;
  always_comb begin
    is_flag = rx_st_flag_i && (rx_data_i == FLAG);
    bad_flag = rx_st_flag_i && (rx_data_i != FLAG);
    last_wr = wr_ptr_q == AW'(len_q - 8'd1);
    last_rd = rd_ptr_q == AW'(len_q - 8'd1);
    state_d = state_q;
    len_d = len_q;
    chk_d = chk_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_code_d = err_code_q;
    frame_ok_d = 1'b0;
    frame_err_d = 1'b0;
    drop_d = 1'b0;
    wr_en = 1'b0;
    case (state_q)
      IDLE: state_d = (rx_valid_i && is_flag) ? HDR : IDLE;
      HDR: if (rx_valid_i && !is_flag) begin
        if (bad_flag) begin
          frame_err_d = 1'b1;
          err_code_d = 2'd3;
          state_d = IDLE;
        end else if (rx_data_i == 8'd0 || rx_data_i > 8'(DEPTH)) begin
          frame_err_d = 1'b1;
          err_code_d = 2'd1;
          state_d = IDLE;
        end else begin
          len_d = rx_data_i;
          chk_d = rx_data_i;
          wr_ptr_d = '0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (rx_valid_i) begin
        if (rx_st_flag_i) begin
          frame_err_d = 1'b1;
          err_code_d = 2'd3;
          state_d = is_flag ? HDR : IDLE;
        end else begin
          wr_en = 1'b1;
          chk_d = chk_q ^ rx_data_i;
          wr_ptr_d = last_wr ? wr_ptr_q : wr_ptr_q + 1'b1;
          state_d = last_wr ? CHK : PAYLOAD;
        end
      end
      CHK: if (rx_valid_i) begin
        if (rx_st_flag_i) begin
          frame_err_d = 1'b1;
          err_code_d = 2'd3;
          state_d = is_flag ? HDR : IDLE;
        end else if (rx_data_i == chk_q) begin
          state_d = END;
        end else begin
          frame_err_d = 1'b1;
          err_code_d = 2'd2;
          state_d = IDLE;
        end
      end
      END: if (rx_valid_i) begin
        if (is_flag) begin
          frame_ok_d = 1'b1;
          rd_ptr_d = '0;
          state_d = DRAIN;
        end else begin
          frame_err_d = 1'b1;
          err_code_d = 2'd3;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        drop_d = rx_valid_i;
        if (m_ready_i) begin
          rd_ptr_d = last_rd ? rd_ptr_q : rd_ptr_q + 1'b1;
          state_d = last_rd ? IDLE : DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q <= '0;
      chk_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_code_q <= '0;
      frame_ok_q <= 1'b0;
      frame_err_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      chk_q <= chk_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_code_q <= err_code_d;
      frame_ok_q <= frame_ok_d;
      frame_err_q <= frame_err_d;
      drop_q <= drop_d;
    end
  end
  // payload storage needs no reset; contents are only read after a full frame is written
  always_ff @(posedge clk) begin
    if (wr_en && !reset) buf_q[wr_ptr_q] <= rx_data_i;
  end
  assign m_valid_o = state_q == DRAIN;
  assign m_data_o = m_valid_o ? buf_q[rd_ptr_q] : 8'd0;
  assign m_sof_o = m_valid_o && rd_ptr_q == '0;
  assign m_eof_o = m_valid_o && last_rd;
  assign frame_ok_o = frame_ok_q;
  assign frame_err_o = frame_err_q;
  assign err_code_o = err_code_q;
  assign drop_o = drop_q;
endmodule
